// File: rtl/mac_array_ctrl_pkg.sv
// Shared definitions for the MAC array controller: FSM state encoding and
// the instruction codes driven onto the array's inst_w bus.
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

endpackage

// File: rtl/mac_ctrl_addr_gen.sv
// SRAM address generator: a base register plus an offset counter; the sum
// wraps naturally at the address width. Re-based at every phase change.
module mac_ctrl_addr_gen #(
  parameter int addr_bw = 11,
  parameter int off_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rebase,
  input  logic [addr_bw-1:0] new_base,
  input  logic               step,
  output logic [addr_bw-1:0] addr,
  output logic [off_bw-1:0]  offset
);

  logic [addr_bw-1:0] base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base   <= '0;
      offset <= '0;
    end else if (rebase) begin
      base   <= new_base;
      offset <= '0;
    end else if (step) begin
      offset <= offset + 1'b1;
    end
  end

  assign addr = base + addr_bw'(offset);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a systolic MAC array: streams col kernel words, then nvec
// activation vectors, then waits for nvec results before pulsing done.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  nvec,
  input  logic [addr_bw-1:0] k_base,
  input  logic [addr_bw-1:0] a_base,
  input  logic               mode_cfg,
  input  logic               dmode_cfg,
  input  logic [col-1:0]     valid_in,
  output logic               sram_rd,
  output logic [addr_bw-1:0] sram_addr,
  output logic [1:0]         inst_w,
  output logic               mode,
  output logic               data_mode,
  output logic               busy,
  output logic               done,
  output logic [cnt_bw-1:0]  out_cnt
);

  // Offset counter must cover both the kernel length and the vector count.
  localparam int load_bw = $clog2(col) + 1;
  localparam int off_bw  = (cnt_bw > load_bw) ? cnt_bw : load_bw;
  localparam int unused_rows = row;

  state_t             state, state_next;
  logic [cnt_bw-1:0]  nvec_reg;
  logic [addr_bw-1:0] a_base_reg;
  logic [cnt_bw-1:0]  out_cnt_next;
  logic               rebase, step, accept;
  logic [addr_bw-1:0] new_base;
  logic [off_bw-1:0]  offset;
  logic               unused_valid;

  assign unused_valid = ^valid_in;
  assign accept       = (state == IDLE) && start;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  mac_ctrl_addr_gen #(.addr_bw(addr_bw), .off_bw(off_bw)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .rebase   (rebase),
    .new_base (new_base),
    .step     (step),
    .addr     (sram_addr),
    .offset   (offset)
  );

  always_comb begin
    out_cnt_next = out_cnt;
    if (accept)
      out_cnt_next = '0;
    else if (busy && valid_in[col-1] && (out_cnt != '1))
      out_cnt_next = out_cnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    rebase     = 1'b0;
    new_base   = k_base;
    step       = 1'b0;
    sram_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          rebase     = 1'b1;
        end
      end
      LOAD: begin
        sram_rd = 1'b1;
        step    = 1'b1;
        if (offset == off_bw'(col - 1)) begin
          if (nvec_reg == '0) begin
            state_next = DONE;
          end else begin
            state_next = EXEC;
            rebase     = 1'b1;
            new_base   = a_base_reg;
          end
        end
      end
      EXEC: begin
        sram_rd = 1'b1;
        step    = 1'b1;
        if (offset == off_bw'(nvec_reg - cnt_bw'(1)))
          state_next = DRAIN;
      end
      // Results seen during EXEC already count, so compare with >=.
      DRAIN:   if (out_cnt_next >= nvec_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      nvec_reg   <= '0;
      a_base_reg <= '0;
      mode       <= 1'b0;
      data_mode  <= 1'b0;
      out_cnt    <= '0;
      inst_w     <= INST_IDLE;
    end else begin
      state   <= state_next;
      out_cnt <= out_cnt_next;
      if (accept) begin
        nvec_reg   <= nvec;
        a_base_reg <= a_base;
        mode       <= mode_cfg;
        data_mode  <= dmode_cfg;
      end
      case (state)
        LOAD:    inst_w <= INST_LOAD;
        EXEC:    inst_w <= INST_EXEC;
        default: inst_w <= INST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: directed table of passes, a reset
// mid-pass sequence, and randomized passes against a timeline model.
module tb_mac_array_ctrl;

  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] nvec;
  logic [AW-1:0] k_base, a_base;
  logic          mode_cfg, dmode_cfg;
  logic [COL-1:0] valid_in;
  logic          sram_rd;
  logic [AW-1:0] sram_addr;
  logic [1:0]    inst_w;
  logic          mode, data_mode, busy, done;
  logic [CW-1:0] out_cnt;

  mac_array_ctrl #(.row(8), .col(COL), .addr_bw(AW), .cnt_bw(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .nvec(nvec),
    .k_base(k_base), .a_base(a_base), .mode_cfg(mode_cfg), .dmode_cfg(dmode_cfg),
    .valid_in(valid_in), .sram_rd(sram_rd), .sram_addr(sram_addr), .inst_w(inst_w),
    .mode(mode), .data_mode(data_mode), .busy(busy), .done(done), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int nvec; int kb; int ab; bit m; bit dm;
    int pstart; int gap; int npulse;
    int exp_done; int exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit pulse_at(input vec_t v, input int c);
    if (c < v.pstart || v.npulse == 0) return 1'b0;
    return ((c - v.pstart) % v.gap == 0) && ((c - v.pstart) / v.gap < v.npulse);
  endfunction

  function automatic int pulses_upto(input vec_t v, input int c);
    int n = 0;
    for (int t = 1; t <= c; t++) if (pulse_at(v, t)) n++;
    return (n > 255) ? 255 : n;
  endfunction

  // Cycle (1 = first cycle after the accepting edge) in which done is high.
  function automatic int model_done(input vec_t v);
    if (v.nvec == 0) return COL + 1;
    for (int t = COL + v.nvec + 1; t < 2000; t++)
      if (pulses_upto(v, t) >= v.nvec) return t + 1;
    return -1;
  endfunction

  task automatic run_pass(input vec_t v, input string tag, input bit wait_neg);
    int r;
    logic [1:0] exp_inst;
    r = COL + v.nvec;
    if (wait_neg) @(negedge clk);
    start = 1'b1; nvec = CW'(v.nvec); k_base = AW'(v.kb); a_base = AW'(v.ab);
    mode_cfg = v.m; dmode_cfg = v.dm; valid_in = '0;
    @(posedge clk);
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (c == 5) begin
        nvec = CW'($urandom); k_base = AW'($urandom); a_base = AW'($urandom);
        mode_cfg = ~v.m; dmode_cfg = ~v.dm;
      end
      valid_in = {(c <= v.exp_done) ? pulse_at(v, c) : 1'b0, 7'($urandom)};
      #1;
      if (c == 1 || c - 1 == COL || c - 1 == r)
        exp_inst = 2'b00;
      exp_inst = (c - 1 >= 1 && c - 1 <= COL) ? 2'b01 :
                 (c - 1 > COL && c - 1 <= r) ? 2'b10 : 2'b00;
      chk({tag, " inst_w"}, 32'(inst_w), 32'(exp_inst));
      chk({tag, " mode"}, {31'd0, mode}, {31'd0, v.m});
      chk({tag, " data_mode"}, {31'd0, data_mode}, {31'd0, v.dm});
      if (c <= v.exp_done) begin
        chk({tag, " busy"}, {31'd0, busy}, 32'd1);
        chk({tag, " sram_rd"}, {31'd0, sram_rd}, {31'd0, c <= r});
        if (c <= COL)
          chk({tag, " k_addr"}, 32'(sram_addr), (v.kb + c - 1) & 32'h7FF);
        else if (c <= r)
          chk({tag, " a_addr"}, 32'(sram_addr), (v.ab + c - COL - 1) & 32'h7FF);
        chk({tag, " done"}, {31'd0, done}, {31'd0, c == v.exp_done});
        chk({tag, " out_cnt"}, 32'(out_cnt), 32'(pulses_upto(v, c - 1)));
      end else begin
        chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle done"}, {31'd0, done}, 32'd0);
        chk({tag, " idle sram_rd"}, {31'd0, sram_rd}, 32'd0);
        chk({tag, " final out_cnt"}, 32'(out_cnt), 32'(v.exp_cnt));
      end
    end
    start = 1'b0; valid_in = '0;
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    tbl[0] = '{nvec:4,   kb:'h010, ab:'h100, m:1, dm:0, pstart:10, gap:1, npulse:4,   exp_done:14,  exp_cnt:4};
    tbl[1] = '{nvec:0,   kb:'h200, ab:'h300, m:0, dm:1, pstart:1,  gap:1, npulse:0,   exp_done:9,   exp_cnt:0};
    tbl[2] = '{nvec:3,   kb:'h020, ab:'h040, m:1, dm:1, pstart:12, gap:2, npulse:3,   exp_done:17,  exp_cnt:3};
    tbl[3] = '{nvec:4,   kb:'h7FC, ab:'h7FE, m:0, dm:0, pstart:3,  gap:2, npulse:4,   exp_done:14,  exp_cnt:4};
    tbl[4] = '{nvec:2,   kb:'h055, ab:'h0AA, m:1, dm:0, pstart:2,  gap:1, npulse:5,   exp_done:12,  exp_cnt:5};
    tbl[5] = '{nvec:1,   kb:'h111, ab:'h222, m:0, dm:1, pstart:30, gap:1, npulse:1,   exp_done:31,  exp_cnt:1};
    tbl[6] = '{nvec:255, kb:'h400, ab:'h700, m:1, dm:1, pstart:1,  gap:1, npulse:300, exp_done:265, exp_cnt:255};

    reset = 1'b1; start = 1'b0; nvec = '0; k_base = '0; a_base = '0;
    mode_cfg = 1'b0; dmode_cfg = 1'b0; valid_in = '0;
    #2;
    chk("rst sram_rd", {31'd0, sram_rd}, 32'd0);
    chk("rst sram_addr", 32'(sram_addr), 32'd0);
    chk("rst inst_w", 32'(inst_w), 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst out_cnt", 32'(out_cnt), 32'd0);
    chk("rst mode", {30'd0, mode, data_mode}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      run_pass(tbl[i], $sformatf("tbl%0d", i), i != 0);

    // Reset in the middle of EXEC, then a start on the first edge after release.
    rv = '{nvec:5, kb:'h030, ab:'h050, m:1, dm:1, pstart:2, gap:1, npulse:2, exp_done:0, exp_cnt:0};
    @(negedge clk);
    start = 1'b1; nvec = 8'd5; k_base = 11'h030; a_base = 11'h050;
    mode_cfg = 1'b1; dmode_cfg = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= COL + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      valid_in = {pulse_at(rv, c), 7'd0};
    end
    #1;
    chk("midexec sram_rd", {31'd0, sram_rd}, 32'd1);
    chk("midexec out_cnt", 32'(out_cnt), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_exec sram_rd", {31'd0, sram_rd}, 32'd0);
    chk("rst_exec inst_w", 32'(inst_w), 32'd0);
    chk("rst_exec busy", {31'd0, busy}, 32'd0);
    chk("rst_exec out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_exec mode", {30'd0, mode, data_mode}, 32'd0);
    chk("rst_exec sram_addr", 32'(sram_addr), 32'd0);
    #1;
    reset = 1'b0; valid_in = '0;
    run_pass(tbl[0], "post_rst", 1'b0);

    for (int i = 0; i < 20; i++) begin
      rv.nvec   = $urandom_range(0, 12);
      rv.kb     = $urandom_range(0, 2047);
      rv.ab     = $urandom_range(0, 2047);
      rv.m      = 1'($urandom);
      rv.dm     = 1'($urandom);
      rv.pstart = $urandom_range(1, 20);
      rv.gap    = $urandom_range(1, 3);
      rv.npulse = rv.nvec + $urandom_range(0, 3);
      rv.exp_done = model_done(rv);
      rv.exp_cnt  = pulses_upto(rv, rv.exp_done);
      run_pass(rv, $sformatf("rnd%0d", i), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
